// File: rtl/fact_bus_master.sv
// Bus master that drives a memory-mapped factorial core: loads the operand,
// enables and starts the core, waits for its interrupt, reads the 128-bit result and clears the core.
module fact_bus_master #(
  parameter logic [15:0] FACT_BASE = 16'h7000,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  operand,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result,
  output logic         m_req,
  input  logic         m_grant,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  input  logic [63:0]  m_din,
  input  logic         interrupt
);

  localparam logic [15:0] OFF_START = 16'h0000;
  localparam logic [15:0] OFF_CLEAR = 16'h0008;
  localparam logic [15:0] OFF_INTEN = 16'h0018;
  localparam logic [15:0] OFF_OPND  = 16'h0020;
  localparam logic [15:0] OFF_RES_H = 16'h0028;
  localparam logic [15:0] OFF_RES_L = 16'h0030;

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ARB, W_OPND, W_INTEN, W_START, WAIT_INT,
    R_L, R_L_CAP, R_H, R_H_CAP, W_CLR1, W_CLR0, DONE
  } state_t;

  state_t             state;
  logic [63:0]        opnd_q;
  logic [CNT_W-1:0]   wait_cnt;

  // NOTE: every register here is updated with <= so all next-state values are
  // computed from the same pre-edge snapshot, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      opnd_q   <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      result   <= '0;
      m_req    <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_dout   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opnd_q <= operand;
            busy   <= 1'b1;
            error  <= 1'b0;
            m_req  <= 1'b1;
            m_wr   <= 1'b0;
            state  <= ARB;
          end
        end
        ARB: begin
          if (m_grant) begin
            m_wr   <= 1'b1;
            m_addr <= FACT_BASE + OFF_OPND;
            m_dout <= opnd_q;
            state  <= W_OPND;
          end
        end
        W_OPND: begin
          if (m_grant) begin
            m_addr <= FACT_BASE + OFF_INTEN;
            m_dout <= 64'd1;
            state  <= W_INTEN;
          end
        end
        W_INTEN: begin
          if (m_grant) begin
            m_addr <= FACT_BASE + OFF_START;
            m_dout <= 64'd1;
            state  <= W_START;
          end
        end
        W_START: begin
          if (m_grant) begin
            m_wr     <= 1'b0;
            m_addr   <= FACT_BASE + OFF_RES_L;
            wait_cnt <= '0;
            state    <= WAIT_INT;
          end
        end
        // The bus stays requested while waiting, but this is not a transfer:
        // the timeout counts every cycle regardless of grant.
        WAIT_INT: begin
          if (interrupt) begin
            state <= R_L;
          end else if (wait_cnt == CNT_LAST) begin
            error  <= 1'b1;
            result <= '0;
            m_wr   <= 1'b1;
            m_addr <= FACT_BASE + OFF_CLEAR;
            m_dout <= 64'd1;
            state  <= W_CLR1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        R_L: begin
          if (m_grant) state <= R_L_CAP;
        end
        R_L_CAP: begin
          if (m_grant) begin
            result[63:0] <= m_din;
            m_addr       <= FACT_BASE + OFF_RES_H;
            state        <= R_H;
          end
        end
        R_H: begin
          if (m_grant) state <= R_H_CAP;
        end
        R_H_CAP: begin
          if (m_grant) begin
            result[127:64] <= m_din;
            m_wr           <= 1'b1;
            m_addr         <= FACT_BASE + OFF_CLEAR;
            m_dout         <= 64'd1;
            state          <= W_CLR1;
          end
        end
        W_CLR1: begin
          if (m_grant) begin
            m_dout <= 64'd0;
            state  <= W_CLR0;
          end
        end
        W_CLR0: begin
          if (m_grant) begin
            m_req <= 1'b0;
            m_wr  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
